fc_mac_scheduler: RTL
=====================

Name: fc_mac_scheduler

Overview:
- Sequences one shared signed multiply-accumulate unit over a fully-connected layer: N_OUT neurons × N_IN inputs, replacing one wide parallel dot-product per neuron.
- Reads activations and weights from external synchronous RAMs (1-cycle read latency), accumulates, adds per-neuron bias, emits one result per neuron.
- Sits between the last pooling-stage activation buffer and the classifier/argmax stage.

Parameters:
- N_IN, 3136, inputs per neuron (flattened activation length)
- N_OUT, 10, number of output neurons
- ACT_W, 30, signed activation width
- W_W, 9, signed weight/bias width
- ACC_W, 38, signed accumulator/output width
- AW, 12, activation address width (≥ clog2(N_IN))
- WAW, 15, weight address width (≥ clog2(N_IN*N_OUT))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a layer pass when idle
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse, coincides with final out_valid
- act_rd  out  1  activation RAM read enable
- act_addr  out  AW  activation index k
- act_data  in  ACT_W  signed, valid cycle after act_rd
- w_rd  out  1  weight RAM read enable
- w_addr  out  WAW  n*N_IN + k
- w_data  in  W_W  signed, valid cycle after w_rd
- bias_idx  out  clog2(N_OUT)  current neuron n (combinational from state)
- bias_data  in  W_W  signed, sampled in BIAS state
- out_valid  out  1  one-cycle pulse per neuron
- out_idx  out  clog2(N_OUT)  neuron index of out_data
- out_data  out  ACC_W  signed neuron result

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, act_rd, w_rd, out_valid = 0; act_addr, w_addr, out_idx, out_data, accumulator, counters = 0. Reset mid-pass abandons the pass; no out_valid/done follows.
- States: IDLE, RUN, DRAIN, BIAS, DONE.
- IDLE: start=1 → RUN, n=0, k=0, acc=0. start while not IDLE ignored.
- RUN: act_rd=w_rd=1, act_addr=k, w_addr=n*N_IN+k (running offset register, no multiplier). rd_q pipelines read enable one cycle; when rd_q=1, acc += act_data*w_data. k increments; at k=N_IN-1 → DRAIN.
- DRAIN: no reads; last product accumulates → BIAS.
- BIAS: out_data <= acc + sign-extended bias_data; out_idx <= n; out_valid <= 1 (visible next cycle). If n=N_OUT-1 → DONE, else n++, k=0, acc=0 → RUN.
- DONE: done=1 for one cycle (same cycle as last out_valid) → IDLE.
- Latency: first out_valid N_IN+3 cycles after start sampled; subsequent every N_IN+2 cycles; total pass N_OUT*(N_IN+2)+1 cycles.
- Arithmetic: full ACT_W+W_W product, sign-extended or truncated to ACC_W; accumulation and bias add wrap modulo 2^ACC_W (two's complement), no saturation.
- Read enables never asserted outside RUN; addresses hold last value when idle.
- start coincident with done: ignored (state is DONE, not IDLE).

Optional Feature:
- Macro FC_SCHED_RELU_EN. Defined: out_data = 0 when acc+bias negative, else acc+bias (ReLU fused in BIAS state, no added latency). Undefined: raw signed acc+bias output.

Test Plan:
- N_IN=4,N_OUT=2; act=[1,2,3,4], w0=[1,1,1,1], b0=5 → out_valid idx0 out_data=15 at cycle 7 after start edge.
- Same run, w1=[-1,-2,-3,-4], b1=0 → idx1 out_data=-30 at cycle 13, done=1 same cycle, busy low cycle 14; with FC_SCHED_RELU_EN → 0.
- Address trace: w_addr sequence 0,1,2,3 then 4,5,6,7; act_addr 0..3 twice; act_rd/w_rd high exactly 8 cycles.
- start pulsed at cycles 3 and 13 during pass → ignored; exactly 2 out_valid and one done.
- rst_n low at cycle 5 → all outputs 0 immediately; no out_valid; new start after release gives correct 15/-30.
- Overflow: act=2^29-1, w=255 all four, ACC_W=38 → out_data equals wrapped 38-bit two's complement sum (bench model check).

Source files
------------

// File: rtl/fc_mac_scheduler_if.sv
// Bundle of control, RAM-read and result signals between the FC-layer MAC scheduler
// and its surroundings; the scheduler takes the master side.
interface fc_mac_scheduler_if #(
  parameter int N_OUT = 10,
  parameter int ACT_W = 30,
  parameter int W_W   = 9,
  parameter int ACC_W = 38,
  parameter int AW    = 12,
  parameter int WAW   = 15
);
  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    act_rd;
  logic [AW-1:0]           act_addr;
  logic signed [ACT_W-1:0] act_data;
  logic                    w_rd;
  logic [WAW-1:0]          w_addr;
  logic signed [W_W-1:0]   w_data;
  logic [NW-1:0]           bias_idx;
  logic signed [W_W-1:0]   bias_data;
  logic                    out_valid;
  logic [NW-1:0]           out_idx;
  logic signed [ACC_W-1:0] out_data;

  modport master (
    input  start, act_data, w_data, bias_data,
    output busy, done, act_rd, act_addr, w_rd, w_addr, bias_idx,
           out_valid, out_idx, out_data
  );

  modport slave (
    output start, act_data, w_data, bias_data,
    input  busy, done, act_rd, act_addr, w_rd, w_addr, bias_idx,
           out_valid, out_idx, out_data
  );
endinterface

// File: rtl/fc_mac_scheduler.sv
// Time-multiplexes one signed MAC over an N_OUT x N_IN fully-connected layer.
// Optional macro FC_SCHED_RELU_EN fuses a ReLU into the bias stage.
module fc_mac_scheduler #(
  parameter int N_IN  = 3136,
  parameter int N_OUT = 10,
  parameter int ACT_W = 30,
  parameter int W_W   = 9,
  parameter int ACC_W = 38,
  parameter int AW    = 12,
  parameter int WAW   = 15
) (
  input  logic clk,
  input  logic rst_n,
  fc_mac_scheduler_if.master bus
);
  localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PW = ACT_W + W_W;
  localparam int MW = (PW > ACC_W) ? PW : ACC_W;
  localparam int BW = (W_W > ACC_W) ? W_W : ACC_W;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_BIAS, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [AW-1:0]           k;
  logic [WAW-1:0]          w_off;
  logic [NW-1:0]           n;
  logic                    vld_p1;
  logic signed [PW-1:0]    prod_p1;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] out_data_r;
  logic [NW-1:0]           out_idx_r;
  logic                    out_valid_r;
  logic                    busy_c, done_c, rd_c;
  logic                    last_k, last_n;

  function automatic logic signed [ACC_W-1:0] fit_prod(input logic signed [PW-1:0] p);
    logic signed [MW-1:0] wide;
    wide = p;
    return wide[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] fit_bias(input logic signed [W_W-1:0] b);
    logic signed [BW-1:0] wide;
    wide = b;
    return wide[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] shape_out(input logic signed [ACC_W-1:0] sum);
`ifdef FC_SCHED_RELU_EN
    return sum[ACC_W-1] ? '0 : sum;
`else
    return sum;
`endif
  endfunction

  assign last_k  = (k == AW'(N_IN - 1));
  assign last_n  = (n == NW'(N_OUT - 1));
  assign prod_p1 = PW'(bus.act_data) * PW'(bus.w_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    rd_c      = 1'b0;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_RUN;
      S_RUN: begin
        busy_c = 1'b1;
        rd_c   = 1'b1;
        if (last_k) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy_c    = 1'b1;
        state_nxt = S_BIAS;
      end
      S_BIAS: begin
        busy_c    = 1'b1;
        state_nxt = last_n ? S_DONE : S_RUN;
      end
      S_DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: addresses issued in RUN; stage p1: RAM data returns, product accumulates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      w_off       <= '0;
      n           <= '0;
      vld_p1      <= 1'b0;
      acc         <= '0;
      out_data_r  <= '0;
      out_idx_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      vld_p1      <= (state == S_RUN);
      out_valid_r <= 1'b0;
      if (vld_p1) acc <= acc + fit_prod(prod_p1);
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            k     <= '0;
            w_off <= '0;
            n     <= '0;
            acc   <= '0;
          end
        end
        S_RUN: begin
          // Weight address is a running offset, so it stays put on the last tap
          // and steps to the next neuron's row on leaving BIAS.
          if (!last_k) begin
            k     <= k + 1'b1;
            w_off <= w_off + 1'b1;
          end
        end
        S_BIAS: begin
          out_data_r  <= shape_out(acc + fit_bias(bus.bias_data));
          out_idx_r   <= n;
          out_valid_r <= 1'b1;
          if (!last_n) begin
            n     <= n + 1'b1;
            k     <= '0;
            w_off <= w_off + 1'b1;
            acc   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p2: registered neuron result
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.act_rd    = rd_c;
  assign bus.w_rd      = rd_c;
  assign bus.act_addr  = k;
  assign bus.w_addr    = w_off;
  assign bus.bias_idx  = n;
  assign bus.out_valid = out_valid_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_data  = out_data_r;
endmodule
